// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port ids, default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arb_pkg;

    // LOCKED is only reachable when the build defines MEM_ARB_LOCK_EN.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP   = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_EXT  = 1'b1;

    localparam int DEF_AW = 12;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie the port that did not win last time is picked.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports:
//   req[1:0]  requesting ports
//   last      id of the previous winner
//   gnt[1:0]  one-hot grant (all zero when nothing requests)
//   winner    id of the granted port (0 when nothing requests)
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
        if (|req) begin
            gnt = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous memory between the core (port 0) and an external loader (port 1).
// Latency: grant is same-cycle; writes complete in the grant cycle; read data returns one cycle after grant.
// Backpressure: a port waits with req held until gnt; no grants while read data is returning.
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   pN_req/we/addr/wdata/wstrb  request from port N (held until pN_gnt)
//   pN_gnt               request accepted this cycle
//   pN_rvalid/rdata      read data return, only to the port that issued the read
//   p1_lock              external port ownership hold (MEM_ARB_LOCK_EN builds only)
//   mem_*                memory strobe/address/data; mem_rdata valid the cycle after a read strobe
//
// Build option: define MEM_ARB_LOCK_EN to let port 1 hold exclusive ownership via p1_lock.
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [AW-1:0]     p0_addr,
    input  logic [DW-1:0]     p0_wdata,
    input  logic [DW/8-1:0]   p0_wstrb,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DW-1:0]     p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [AW-1:0]     p1_addr,
    input  logic [DW-1:0]     p1_wdata,
    input  logic [DW/8-1:0]   p1_wstrb,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DW-1:0]     p1_rdata,
    input  logic              p1_lock,

    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb,
    input  logic [DW-1:0]     mem_rdata
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;

`ifdef MEM_ARB_LOCK_EN
    // Set while port 1 holds ownership; lets RESP know to fall back into LOCKED.
    logic       own_q, own_d;
`else
    logic       unused_p1_lock;
    assign unused_p1_lock = p1_lock;
`endif

    logic [1:0] req_eff;
    logic [1:0] pick_gnt;
    logic       pick_id;
    logic       any_gnt;
    logic       sel_we;

    // Only requests eligible in the current state reach the picker; reset
    // suppresses grants even though the state register already reads IDLE.
    always_comb begin
        req_eff = 2'b00;
        if (!reset) begin
            case (state_q)
                ST_IDLE:   req_eff = {p1_req, p0_req};
`ifdef MEM_ARB_LOCK_EN
                ST_LOCKED: req_eff = {p1_req & p1_lock, 1'b0};
`endif
                default:   req_eff = 2'b00;
            endcase
        end
    end

    rr_pick2 u_pick (
        .req    (req_eff),
        .last   (last_q),
        .gnt    (pick_gnt),
        .winner (pick_id)
    );

    assign any_gnt = |pick_gnt;
    assign sel_we  = pick_id ? p1_we : p0_we;
    assign p0_gnt  = pick_gnt[0];
    assign p1_gnt  = pick_gnt[1];

    // Memory side is driven straight from the winner in the grant cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (any_gnt) begin
            mem_en    = 1'b1;
            mem_we    = sel_we;
            mem_addr  = pick_id ? p1_addr  : p0_addr;
            mem_wdata = pick_id ? p1_wdata : p0_wdata;
            if (sel_we) begin
                mem_wstrb = pick_id ? p1_wstrb : p0_wstrb;
            end
        end
    end

    // Read return: the memory's registered output is steered to the owner only.
    assign p0_rvalid = (state_q == ST_RESP) && (owner_q == PORT_CORE);
    assign p1_rvalid = (state_q == ST_RESP) && (owner_q == PORT_EXT);
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
`ifdef MEM_ARB_LOCK_EN
        own_d   = own_q;
`endif
        if (any_gnt) begin
            last_d = pick_id;
        end
        case (state_q)
            ST_IDLE: begin
                if (any_gnt && !sel_we) begin
                    state_d = ST_RESP;
                    owner_d = pick_id;
                end
`ifdef MEM_ARB_LOCK_EN
                if (any_gnt && (pick_id == PORT_EXT) && p1_lock) begin
                    own_d = 1'b1;
                    if (sel_we) begin
                        state_d = ST_LOCKED;
                    end
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
`ifdef MEM_ARB_LOCK_EN
                if (own_q && p1_lock) begin
                    state_d = ST_LOCKED;
                end else if (own_q) begin
                    own_d  = 1'b0;
                    last_d = PORT_EXT;
                end
`endif
            end
`ifdef MEM_ARB_LOCK_EN
            ST_LOCKED: begin
                if (!p1_lock) begin
                    state_d = ST_IDLE;
                    own_d   = 1'b0;
                    last_d  = PORT_EXT;
                end else if (any_gnt && !sel_we) begin
                    state_d = ST_RESP;
                    owner_d = PORT_EXT;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= PORT_EXT;
            owner_q <= PORT_CORE;
`ifdef MEM_ARB_LOCK_EN
            own_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
`ifdef MEM_ARB_LOCK_EN
            own_q   <= own_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed sequences, randomized traffic.
// Latency: n/a.
// Backpressure: requesters hold their request until granted.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic [3:0]    p0_wstrb, p1_wstrb;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_rdata;

    always #5 clock = ~clock;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wstrb(p0_wstrb), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wstrb(p1_wstrb), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_lock(p1_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory; mem_init reloads known contents.
    logic          mem_init;
    logic [31:0]   mem_arr [0:4095];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem_arr[i] <= (i == 16) ? 32'hDEADBEEF : 32'h0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem_arr[mem_addr];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
        p1_lock = 0;
    endtask

    // Holds reset with a pending p0 request to confirm nothing is granted meanwhile.
    task automatic do_reset();
        idle_inputs();
        reset = 1; mem_init = 1;
        p0_req = 1;
        @(negedge clock);
        chk("RST p0_gnt", {31'b0, p0_gnt}, 0);
        chk("RST mem_en", {31'b0, mem_en}, 0);
        chk("RST p0_rvalid", {31'b0, p0_rvalid}, 0);
        chk("RST p1_rdata", p1_rdata, 0);
        tick();
        reset = 0; mem_init = 0;
        p0_req = 0;
    endtask

    typedef struct packed {
        logic r0, w0, r1, w1;
        logic eg0, eg1, een, ewe;
        logic [11:0] eaddr;
        logic [3:0]  estrb;
        logic erv0, erv1;
    } vec_t;
    vec_t vecs [12];

    // Random-phase requester and reference state.
    logic        pend [2];
    logic        rwe  [2];
    logic [11:0] raddr[2];
    logic [31:0] rwd  [2];
    logic [3:0]  rstb [2];
    logic [31:0] gold [0:15];
    int          rv_owner;
    logic [31:0] rv_data;
    int          last_w;
    int          eg;

    initial begin
        idle_inputs();
        reset = 1; mem_init = 1;
        repeat (2) @(posedge clock);
        #1;

        // ---- p0 read of preloaded word
        do_reset();
        p0_req = 1; p0_we = 0; p0_addr = 12'h010;
        @(negedge clock);
        chk("A p0_gnt", {31'b0, p0_gnt}, 1);
        chk("A mem_addr", {20'b0, mem_addr}, 32'h010);
        chk("A mem_wstrb", {28'b0, mem_wstrb}, 0);
        tick();
        p0_req = 0;
        @(negedge clock);
        chk("A p0_rvalid", {31'b0, p0_rvalid}, 1);
        chk("A p0_rdata", p0_rdata, 32'hDEADBEEF);
        chk("A p1_rvalid", {31'b0, p1_rvalid}, 0);
        chk("A p1_rdata", p1_rdata, 0);
        chk("A p0_gnt resp", {31'b0, p0_gnt}, 0);
        tick();

        // ---- simultaneous writes
        do_reset();
        p0_req = 1; p0_we = 1; p0_addr = 12'h004; p0_wdata = 32'h11111111; p0_wstrb = 4'hF;
        p1_req = 1; p1_we = 1; p1_addr = 12'h008; p1_wdata = 32'h22222222; p1_wstrb = 4'hF;
        @(negedge clock);
        chk("B c0 p0_gnt", {31'b0, p0_gnt}, 1);
        chk("B c0 p1_gnt", {31'b0, p1_gnt}, 0);
        tick();
        p0_req = 0;
        @(negedge clock);
        chk("B c1 p1_gnt", {31'b0, p1_gnt}, 1);
        chk("B c1 p0_gnt", {31'b0, p0_gnt}, 0);
        tick();
        p1_req = 0;
        @(negedge clock);
        chk("B mem[4]", mem_arr[4], 32'h11111111);
        chk("B mem[8]", mem_arr[8], 32'h22222222);
        tick();

        // ---- continuous reads from both ports
        p0_req = 1; p0_we = 0; p1_req = 1; p1_we = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            chk($sformatf("C%0d p0_gnt", c), {31'b0, p0_gnt}, (c % 4 == 0) ? 1 : 0);
            chk($sformatf("C%0d p1_gnt", c), {31'b0, p1_gnt}, (c % 4 == 2) ? 1 : 0);
            chk($sformatf("C%0d p0_rvalid", c), {31'b0, p0_rvalid}, (c % 4 == 1) ? 1 : 0);
            chk($sformatf("C%0d p1_rvalid", c), {31'b0, p1_rvalid}, (c % 4 == 3) ? 1 : 0);
            chk($sformatf("C%0d p0_rdata", c), p0_rdata, (c % 4 == 1) ? 32'h11111111 : 0);
            chk($sformatf("C%0d p1_rdata", c), p1_rdata, (c % 4 == 3) ? 32'h22222222 : 0);
            tick();
        end
        p0_req = 0; p1_req = 0;

        // ---- partial-strobe write then read back
        p1_req = 1; p1_we = 1; p1_addr = 12'h020; p1_wdata = 32'hAABBCCDD; p1_wstrb = 4'h3;
        @(negedge clock);
        chk("D wr p1_gnt", {31'b0, p1_gnt}, 1);
        chk("D wr mem_wstrb", {28'b0, mem_wstrb}, 32'h3);
        tick();
        p1_we = 0;
        @(negedge clock);
        chk("D rd p1_gnt", {31'b0, p1_gnt}, 1);
        chk("D rd mem_wstrb", {28'b0, mem_wstrb}, 0);
        tick();
        p1_req = 0;
        @(negedge clock);
        chk("D p1_rvalid", {31'b0, p1_rvalid}, 1);
        chk("D p1_rdata", p1_rdata, 32'h0000CCDD);
        tick();

        // ---- reset while read data is returning
        p0_req = 1; p0_we = 0; p0_addr = 12'h010;
        @(negedge clock);
        chk("E p0_gnt", {31'b0, p0_gnt}, 1);
        tick();
        chk("E p0_rvalid pre", {31'b0, p0_rvalid}, 1);
        reset = 1;
        #1;
        chk("E p0_rvalid in rst", {31'b0, p0_rvalid}, 0);
        chk("E p0_rdata in rst", p0_rdata, 0);
        chk("E p0_gnt in rst", {31'b0, p0_gnt}, 0);
        @(posedge clock);
        #1;
        reset = 0;
        @(negedge clock);
        chk("E regrant", {31'b0, p0_gnt}, 1);
        tick();
        p0_req = 0;
        tick();

        // ---- vector table, starting from reset (port 0 wins first tie)
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 12'h000, 4'h0, 1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b1, 12'h100, 4'hF, 1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b1, 12'h200, 4'h3, 1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b1, 12'h100, 4'hF, 1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0, 12'h200, 4'h0, 1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 12'h000, 4'h0, 1'b0,1'b1};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b1, 12'h100, 4'hF, 1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 12'h100, 4'h0, 1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 12'h000, 4'h0, 1'b1,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0, 12'h200, 4'h0, 1'b0,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 12'h000, 4'h0, 1'b0,1'b1};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b1, 12'h100, 4'hF, 1'b0,1'b0};
        do_reset();
        for (int v = 0; v < 12; v++) begin
            p0_req = vecs[v].r0; p0_we = vecs[v].w0; p0_addr = 12'h100;
            p0_wdata = 32'h0A0A0A0A; p0_wstrb = 4'hF;
            p1_req = vecs[v].r1; p1_we = vecs[v].w1; p1_addr = 12'h200;
            p1_wdata = 32'h0B0B0B0B; p1_wstrb = 4'h3;
            @(negedge clock);
            chk($sformatf("V%0d p0_gnt", v), {31'b0, p0_gnt}, {31'b0, vecs[v].eg0});
            chk($sformatf("V%0d p1_gnt", v), {31'b0, p1_gnt}, {31'b0, vecs[v].eg1});
            chk($sformatf("V%0d mem_en", v), {31'b0, mem_en}, {31'b0, vecs[v].een});
            chk($sformatf("V%0d mem_we", v), {31'b0, mem_we}, {31'b0, vecs[v].ewe});
            chk($sformatf("V%0d mem_addr", v), {20'b0, mem_addr}, {20'b0, vecs[v].eaddr});
            chk($sformatf("V%0d mem_wstrb", v), {28'b0, mem_wstrb}, {28'b0, vecs[v].estrb});
            chk($sformatf("V%0d p0_rvalid", v), {31'b0, p0_rvalid}, {31'b0, vecs[v].erv0});
            chk($sformatf("V%0d p1_rvalid", v), {31'b0, p1_rvalid}, {31'b0, vecs[v].erv1});
            tick();
        end
        idle_inputs();

        // ---- external port ownership
        do_reset();
        p0_req = 1; p0_we = 1; p0_addr = 12'h030; p0_wdata = 32'h30303030; p0_wstrb = 4'hF;
        @(negedge clock);
        chk("F pre p0_gnt", {31'b0, p0_gnt}, 1);
        tick();
        p0_addr = 12'h032;
        p1_req = 1; p1_we = 1; p1_addr = 12'h031; p1_wdata = 32'h31313131; p1_wstrb = 4'hF;
        p1_lock = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
`ifdef MEM_ARB_LOCK_EN
            chk($sformatf("F%0d p1_gnt", k), {31'b0, p1_gnt}, 1);
            chk($sformatf("F%0d p0_gnt", k), {31'b0, p0_gnt}, 0);
`else
            chk($sformatf("F%0d p1_gnt", k), {31'b0, p1_gnt}, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("F%0d p0_gnt", k), {31'b0, p0_gnt}, (k % 2 == 1) ? 1 : 0);
`endif
            tick();
        end
        p1_req = 0; p1_lock = 0;
        @(negedge clock);
`ifdef MEM_ARB_LOCK_EN
        chk("F release p0_gnt", {31'b0, p0_gnt}, 0);
        tick();
        @(negedge clock);
        chk("F after p0_gnt", {31'b0, p0_gnt}, 1);
`else
        chk("F after p0_gnt", {31'b0, p0_gnt}, 1);
`endif
        tick();
        idle_inputs();

        // ---- randomized traffic against a cycle-level reference
        do_reset();
        @(negedge clock);
        for (int i = 0; i < 16; i++) gold[i] = mem_arr[i];
        tick();
        pend[0] = 0; pend[1] = 0;
        rv_owner = -1; rv_data = '0; last_w = 1;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p]  = 1;
                    rwe[p]   = 1'($urandom_range(0, 1));
                    raddr[p] = 12'($urandom_range(0, 15));
                    rwd[p]   = $urandom;
                    rstb[p]  = 4'($urandom_range(0, 15));
                end
            end
            p0_req = pend[0]; p0_we = rwe[0]; p0_addr = raddr[0]; p0_wdata = rwd[0]; p0_wstrb = rstb[0];
            p1_req = pend[1]; p1_we = rwe[1]; p1_addr = raddr[1]; p1_wdata = rwd[1]; p1_wstrb = rstb[1];
            eg = -1;
            if (rv_owner < 0) begin
                if (pend[0] && pend[1]) eg = 1 - last_w;
                else if (pend[0])      eg = 0;
                else if (pend[1])      eg = 1;
            end
            @(negedge clock);
            chk("R p0_gnt", {31'b0, p0_gnt}, (eg == 0) ? 1 : 0);
            chk("R p1_gnt", {31'b0, p1_gnt}, (eg == 1) ? 1 : 0);
            chk("R mem_en", {31'b0, mem_en}, (eg >= 0) ? 1 : 0);
            if (eg >= 0) begin
                chk("R mem_addr", {20'b0, mem_addr}, {20'b0, raddr[eg]});
                chk("R mem_we", {31'b0, mem_we}, {31'b0, rwe[eg]});
            end
            chk("R p0_rvalid", {31'b0, p0_rvalid}, (rv_owner == 0) ? 1 : 0);
            chk("R p1_rvalid", {31'b0, p1_rvalid}, (rv_owner == 1) ? 1 : 0);
            chk("R p0_rdata", p0_rdata, (rv_owner == 0) ? rv_data : 0);
            chk("R p1_rdata", p1_rdata, (rv_owner == 1) ? rv_data : 0);
            rv_owner = -1;
            if (eg >= 0) begin
                last_w = eg;
                pend[eg] = 0;
                if (rwe[eg]) begin
                    gold[raddr[eg][3:0]] = merge(gold[raddr[eg][3:0]], rwd[eg], rstb[eg]);
                end else begin
                    rv_owner = eg;
                    rv_data  = gold[raddr[eg][3:0]];
                end
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
